// File: rtl/clk_en_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_en_gen_pkg
// Brief    : Shared state encoding and constants for clk_en_gen.
// Revision : 1.0
// ============================================================================
package clk_en_gen_pkg;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  localparam int C_DIV_W_DEFAULT = 16;

  // div_sel stays at least one bit wide even for a single channel
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_en_div.sv
`default_nettype none
// ============================================================================
// Module   : clk_en_div
// Brief    : One clock-enable channel: divisor register, wrap counter, strobe.
// Revision : 1.0
// ============================================================================
module clk_en_div
  import clk_en_gen_pkg::*;
#(
  parameter int DIV_W       = C_DIV_W_DEFAULT,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             run,
  input  logic             run_nxt,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_val,
  output logic             ce
);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic             w_last;

  // Divisors of 0 and 1 both mean "strobe every cycle"
  assign w_last = (r_div <= DIV_W'(1)) || (r_cnt == (r_div - DIV_W'(1)));
  assign ce     = run & w_last;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_div <= DIV_W'(DEFAULT_DIV);
      r_cnt <= '0;
    end else begin
      if (wr) begin
        r_div <= wr_val;
      end
      // Counter only advances across consecutive RUN cycles, so it enters RUN at 0
      if (wr || !run || !run_nxt) begin
        r_cnt <= '0;
      end else if (w_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/clk_en_gen.sv
`default_nettype none
// ============================================================================
// Module   : clk_en_gen
// Brief    : PLL-lock qualified reset release plus NUM_CH programmable
//            clock-enable strobes. Define CLK_EN_GEN_LOSS_COUNT_EN to add the
//            saturating lock_loss_cnt output.
// Revision : 1.0
// ============================================================================
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = C_DIV_W_DEFAULT,
  parameter int LOCK_CYCLES = 1024,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                           clock_in,
  input  logic                           reset,
  input  logic                           pll_locked,
  input  logic                           div_wr,
  input  logic [sel_width(NUM_CH)-1:0]   div_sel,
  input  logic [DIV_W-1:0]               div_val,
  output logic [NUM_CH-1:0]              ce,
  output logic                           rst_out,
  output logic                           ready
`ifdef CLK_EN_GEN_LOSS_COUNT_EN
  ,
  output logic [7:0]                     lock_loss_cnt
`endif
);

  localparam int SEL_W    = sel_width(NUM_CH);
  localparam int SETTLE_W = $clog2(LOCK_CYCLES);
  localparam logic [SETTLE_W-1:0] C_SETTLE_LAST = SETTLE_W'(LOCK_CYCLES - 1);

  logic                r_sync1;
  logic                r_sync2;
  state_t              r_state;
  state_t              w_state_nxt;
  logic [SETTLE_W-1:0] r_settle_cnt;
  logic                r_ready;
  logic                r_rst_out;
  logic                w_run_nxt;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pll_locked;
      r_sync2 <= r_sync1;
    end
  end

  // State register; ready/rst_out are flopped from the next state so they
  // coincide exactly with the RUN state
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_state   <= ST_HOLD;
      r_ready   <= 1'b0;
      r_rst_out <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_ready   <= w_run_nxt;
      r_rst_out <= ~w_run_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_HOLD: begin
        if (r_sync2) w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!r_sync2)                          w_state_nxt = ST_HOLD;
        else if (r_settle_cnt == C_SETTLE_LAST) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!r_sync2) w_state_nxt = ST_HOLD;
      end
      default: w_state_nxt = ST_HOLD;
    endcase
  end

  always_comb begin
    w_run_nxt = (w_state_nxt == ST_RUN);
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_settle_cnt <= '0;
    end else if ((r_state == ST_SETTLE) && (w_state_nxt == ST_SETTLE)) begin
      r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
    end else begin
      r_settle_cnt <= '0;
    end
  end

  assign ready   = r_ready;
  assign rst_out = r_rst_out;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [SEL_W-1:0] C_IDX = SEL_W'(i);
    logic w_wr;

    // Indices at or above NUM_CH never match any channel and are dropped
    assign w_wr = div_wr && (div_sel == C_IDX);

    clk_en_div #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_div (
      .clock_in (clock_in),
      .reset    (reset),
      .run      (r_ready),
      .run_nxt  (w_run_nxt),
      .wr       (w_wr),
      .wr_val   (div_val),
      .ce       (ce[i])
    );
  end

`ifdef CLK_EN_GEN_LOSS_COUNT_EN
  logic [7:0] r_loss_cnt;

  // Only losses out of RUN count; a dropout during SETTLE is not an event
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_loss_cnt <= 8'd0;
    end else if ((r_state == ST_RUN) && (w_state_nxt == ST_HOLD) && (r_loss_cnt != 8'hFF)) begin
      r_loss_cnt <= r_loss_cnt + 8'd1;
    end
  end

  assign lock_loss_cnt = r_loss_cnt;
`else
  // No lock-loss accounting in this build
`endif

endmodule
`default_nettype wire

// File: doc/clk_en_gen.md
CLK_EN_GEN -- requirements
Module: clk_en_gen

Interface
REQ-001 Parameter NUM_CH, default 4: number of clock-enable channels, legal 1..8.
REQ-002 Parameter DIV_W, default 16: divisor width in bits.
REQ-003 Parameter LOCK_CYCLES, default 1024: consecutive synchronised-lock cycles required before release, legal >= 2.
REQ-004 Parameter DEFAULT_DIV, default 2: divisor loaded into every channel at reset.
REQ-005 clock_in  input  1  single system clock (PLL output domain); all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 pll_locked  input  1  raw PLL lock status, asynchronous to clock_in.
REQ-008 div_wr  input  1  divisor write strobe, one cycle.
REQ-009 div_sel  input  max(1,clog2(NUM_CH))  channel index for div_wr.
REQ-010 div_val  input  DIV_W  new divisor value.
REQ-011 ce  output  NUM_CH  per-channel one-cycle clock-enable strobes.
REQ-012 rst_out  output  1  active-high downstream reset, released only when lock is qualified.
REQ-013 ready  output  1  high while in RUN.
REQ-014 lock_loss_cnt  output  8  lock-loss event count (present only under REQ-032).

Function
REQ-015 pll_locked SHALL pass a 2-flop synchroniser; locked_s lags pll_locked by 2 cycles.
REQ-016 FSM states SHALL be HOLD, SETTLE, RUN; reset state HOLD.
REQ-017 HOLD: settle counter = 0; locked_s=1 -> SETTLE next cycle.
REQ-018 SETTLE: counter +1 per cycle while locked_s=1; locked_s=0 -> HOLD, counter cleared; counter = LOCK_CYCLES-1 with locked_s=1 -> RUN.
REQ-019 RUN: locked_s=0 -> HOLD next cycle; no direct RUN->SETTLE path.
REQ-020 rst_out=1 and ready=0 in HOLD and SETTLE; rst_out=0 and ready=1 in RUN; both registered from state.
REQ-021 Per channel i: divisor register div_q[i] (DIV_W) and counter cnt[i] (DIV_W); cnt[i] held at 0 outside RUN.
REQ-022 In RUN, cnt[i] counts 0..div_q[i]-1 and wraps to 0; ce[i]=1 exactly in cycles where cnt[i]=div_q[i]-1, so period = div_q[i] cycles, first pulse in RUN cycle index div_q[i]-1 (ready's first cycle = index 0).
REQ-023 div_q[i] of 0 or 1: ce[i]=1 every RUN cycle.
REQ-024 ce SHALL be all-zero whenever ready=0, with no partial/glitch strobe on RUN exit.
REQ-025 div_wr=1 with div_sel<NUM_CH: div_q[div_sel] <= div_val at that edge and cnt[div_sel] <= 0; accepted in any state; same-value write still restarts the counter.
REQ-026 div_wr with div_sel>=NUM_CH SHALL be ignored.
REQ-027 div_wr coincident with lock loss: divisor update takes effect; counter cleared by HOLD entry.

Reset
REQ-028 reset=1 SHALL at the next edge force: state HOLD, sync flops 0, settle counter 0, all cnt 0, all div_q DEFAULT_DIV, ce 0, rst_out 1, ready 0, lock_loss_cnt 0.
REQ-029 reset SHALL override div_wr and lock activity in the same cycle.
REQ-030 reset mid-RUN SHALL drop ready and ce at the next edge; re-qualification requires full LOCK_CYCLES again.

Configuration
REQ-031 Macro CLK_EN_GEN_LOSS_COUNT_EN SHALL control lock-loss accounting.
REQ-032 Defined: lock_loss_cnt port exists; +1 on each RUN->HOLD transition, saturating at 255; SETTLE->HOLD not counted.
REQ-033 Undefined: lock_loss_cnt port and counter absent; all other behaviour identical.

Structure
REQ-034 Package clk_en_gen_pkg SHALL hold the FSM state typedef (HOLD, SETTLE, RUN) and the DIV_W default constant.
REQ-035 Sub-module clk_en_div SHALL implement one channel (div_q, cnt, ce, write restart), instantiated NUM_CH times via generate.

Verification
REQ-036 Reset, pll_locked=1 constant, LOCK_CYCLES=16 -> rst_out falls and ready rises exactly 2+1+16 cycles after reset release (±0 tolerance, verified against model).
REQ-037 In RUN, default divisors 2 -> each ce toggles 1,0 pattern starting 0,1; write div_sel=1, div_val=5 -> ce[1] first pulse 4 cycles after write edge, then every 5.
REQ-038 pll_locked drops for 1 cycle during SETTLE at count 10 -> return to HOLD, ready delayed by full LOCK_CYCLES after relock; lock_loss_cnt unchanged.
REQ-039 pll_locked drops in RUN -> ce all 0 and rst_out=1 by 3 cycles later; lock_loss_cnt 0->1; 300 losses -> saturates at 255.
REQ-040 div_val=0 and 1 on channel 0 -> ce[0] high every RUN cycle; div_sel=NUM_CH write -> no divisor changes.
REQ-041 reset asserted mid-RUN concurrent with div_wr -> next cycle all outputs at REQ-028 values, div_q[all]=DEFAULT_DIV.
